div_dispatch: RTL and testbench
===============================

DIV_DISPATCH -- requirements
Module: div_dispatch

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 2, meaning log2 of the operand-FIFO depth (4 entries).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port wr_en  input  1  push one operand pair into the FIFO.
REQ-005 SHALL have ports din_x, din_y  input  8 each  dividend and divisor to push.
REQ-006 SHALL have ports full, empty  output  1 each  operand-FIFO status.
REQ-007 SHALL have ports x, y  output  8 each  operands to the divider, registered.
REQ-008 SHALL have port start  output  1  one-cycle divider start pulse.
REQ-009 SHALL have ports done  input  1, and quotient, remainder  input  8 each  divider completion and results.
REQ-010 SHALL have ports res_valid  output  1, res_ready  input  1, and res_q, res_r  output  8 each  result handshake.
REQ-011 SHALL have ports busy  output  1  (FSM not IDLE), and div_err  output  1  (divide-by-zero flag).

Function
REQ-012 SHALL implement a circular FIFO of 2**DEPTH_LOG2 entries, each 16 bits {x,y}, with read/write pointers wrapping modulo depth.
REQ-013 SHALL accept a push only when wr_en=1 and full=0 on the pre-edge state; a push while full is dropped, with no overwrite and no pointer change, even if a pop occurs in the same cycle.
REQ-014 SHALL allow a simultaneous push (not full) and pop, leaving the entry count unchanged.
REQ-015 SHALL use FSM states IDLE, ISSUE, WAIT, HOLD.
REQ-016 IDLE -> ISSUE when empty=0; otherwise stay in IDLE.
REQ-017 In ISSUE, SHALL load x/y from the FIFO head, pop it, drive start=1 for exactly that one cycle, then go to WAIT.
REQ-018 SHALL hold x and y stable from ISSUE until the FSM leaves WAIT.
REQ-019 In WAIT on done=1, SHALL capture quotient into res_q and remainder into res_r, set res_valid=1, and go to HOLD; done outside WAIT is ignored.
REQ-020 In HOLD, SHALL keep res_q, res_r, and res_valid stable until res_valid=1 and res_ready=1 at an edge; it then clears res_valid and goes to IDLE.
REQ-021 Latency: for a push at edge k into an empty FIFO with the FSM in IDLE, start SHALL be high in the cycle following edge k+1.
REQ-022 SHALL never issue a second start before the previous result is accepted, so at most one division is outstanding.
REQ-023 busy SHALL be 1 in ISSUE, WAIT and HOLD.

Reset
REQ-024 reset=1 at an edge SHALL force IDLE, clear both pointers, and set empty=1, full=0, start=0, res_valid=0, busy=0, div_err=0, x=y=res_q=res_r=8'h00.
REQ-025 reset mid-operation (any state) SHALL discard the in-flight division and all FIFO contents; a done arriving after reset is ignored.
REQ-026 reset SHALL take priority over wr_en, done and res_ready in the same cycle.

Configuration
REQ-027 With macro DIV_DISPATCH_ZERO_TRAP_EN defined, a head entry with y=8'h00 SHALL be popped in ISSUE without asserting start, and the block SHALL go directly to HOLD with res_q=8'hFF, res_r=x, div_err=1.
REQ-028 With the macro defined, div_err SHALL clear when the result is accepted.
REQ-029 Without the macro, y=0 SHALL be issued to the divider like any other value, and div_err SHALL be tied to 0.

Verification
REQ-030 Reset 5 cycles, push x=3, y=8, hold res_ready=1 -> one start pulse, x=3 and y=8 held during WAIT, then res_q=0, res_r=3, res_valid for one cycle.
REQ-031 Push 5 pairs on consecutive cycles with the FSM stalled (res_ready=0 after the first result) -> full=1 after the 4th stored entry and the 5th pair absent from the results.
REQ-032 Push pairs (200,7), (255,16), (9,3) with res_ready toggling -> results in order (28,4), (15,15), (3,0), each stable while res_ready=0.
REQ-033 Assert reset during WAIT, then pulse done -> res_valid stays 0, empty=1, busy=0.
REQ-034 With DIV_DISPATCH_ZERO_TRAP_EN, push (42,0) -> no start pulse, res_q=8'hFF, res_r=42, div_err=1; without the macro -> start pulse and div_err=0.

Source files
------------

// File: rtl/div_dispatch.sv
// div_dispatch
//
// Buffers {dividend, divisor} pairs in a small circular FIFO and feeds them
// one at a time to an external multi-cycle divider. Only one division is
// ever outstanding. A new pair is issued only after the previous result has
// been accepted on the result handshake.
//
// Optional build macro: DIV_DISPATCH_ZERO_TRAP_EN
//   When defined, a head entry with divisor 0 is not sent to the divider.
//   The block produces the result {q=8'hFF, r=x} itself and raises div_err
//   until that result is accepted. When undefined, divisor 0 is issued like
//   any other value and div_err is constant 0.
//
// Ports
//   clk, reset          single clock; synchronous active-high reset
//   wr_en, din_x, din_y push one operand pair (dropped while full)
//   full, empty         operand-FIFO status
//   x, y                registered operands to the divider
//   start               one-cycle divider start pulse
//   done, quotient,
//   remainder           divider completion and results
//   res_valid, res_ready,
//   res_q, res_r        result handshake
//   busy                FSM not idle
//   div_err             divide-by-zero flag (trap build only)
//   state_dbg           current FSM state, for debug and checkers
//
// Result handshake: a result transfers on a rising edge where res_valid=1
// and res_ready=1. Once res_valid rises, res_valid, res_q and res_r stay
// stable until that transfer. res_valid never depends on res_ready.

module div_dispatch #(
    parameter int DEPTH_LOG2 = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_en,
    input  logic [7:0] din_x,
    input  logic [7:0] din_y,
    output logic       full,
    output logic       empty,
    output logic [7:0] x,
    output logic [7:0] y,
    output logic       start,
    input  logic       done,
    input  logic [7:0] quotient,
    input  logic [7:0] remainder,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [7:0] res_q,
    output logic [7:0] res_r,
    output logic       busy,
    output logic       div_err,
    output logic [1:0] state_dbg
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t state_q, state_d;

    // ---------------- operand FIFO ----------------
    logic [15:0]           mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
    logic [DEPTH_LOG2:0]   count;
    logic                  push, pop;

    assign full  = (count == DEPTH_CNT);
    assign empty = (count == '0);

    // The full test uses the pre-edge count, so a push while full is dropped
    // even if the head is popped on the same edge.
    assign push = wr_en && !full;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push && !reset) mem[wr_ptr] <= {din_x, din_y};
    end

    // ---------------- zero-divisor trap ----------------
    logic zero_trap;
`ifdef DIV_DISPATCH_ZERO_TRAP_EN
    assign zero_trap = (y == 8'h00);
`else
    assign zero_trap = 1'b0;
`endif

    // ---------------- control FSM ----------------
    logic load_xy, cap_res, trap_res, accept;

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // x/y are loaded on the edge into ISSUE, so they are already valid
    // while start is high. The head is popped on the edge leaving ISSUE.
    always_comb begin
        state_d  = state_q;
        load_xy  = 1'b0;
        pop      = 1'b0;
        start    = 1'b0;
        cap_res  = 1'b0;
        trap_res = 1'b0;
        accept   = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    load_xy = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                pop = 1'b1;
                if (zero_trap) begin
                    trap_res = 1'b1;
                    state_d  = HOLD;
                end else begin
                    start   = 1'b1;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (done) begin
                    cap_res = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (res_valid && res_ready) begin
                    accept  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy      = (state_q != IDLE);
    assign state_dbg = state_q;

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            x         <= 8'h00;
            y         <= 8'h00;
            res_q     <= 8'h00;
            res_r     <= 8'h00;
            res_valid <= 1'b0;
        end else begin
            if (load_xy) {x, y} <= mem[rd_ptr];
            if (cap_res) begin
                res_q     <= quotient;
                res_r     <= remainder;
                res_valid <= 1'b1;
            end
            if (trap_res) begin
                res_q     <= 8'hFF;
                res_r     <= x;
                res_valid <= 1'b1;
            end
            if (accept) res_valid <= 1'b0;
        end
    end

`ifdef DIV_DISPATCH_ZERO_TRAP_EN
    logic div_err_q;
    always_ff @(posedge clk) begin
        if (reset)         div_err_q <= 1'b0;
        else if (trap_res) div_err_q <= 1'b1;
        else if (accept)   div_err_q <= 1'b0;
    end
    assign div_err = div_err_q;
`else
    assign div_err = 1'b0;
`endif

endmodule

// File: tb/tb_div_dispatch.sv
module tb_div_dispatch;

  localparam int W = 17;  // {div_err, res_q, res_r}

`ifdef DIV_DISPATCH_ZERO_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, wr_en, done, res_ready;
  logic [7:0] din_x, din_y, quotient, remainder;
  logic       full, empty, start, res_valid, busy, div_err;
  logic [7:0] x, y, res_q, res_r;
  logic [1:0] state_dbg;

  div_dispatch #(.DEPTH_LOG2(2)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .din_x(din_x), .din_y(din_y),
    .full(full), .empty(empty), .x(x), .y(y), .start(start),
    .done(done), .quotient(quotient), .remainder(remainder),
    .res_valid(res_valid), .res_ready(res_ready), .res_q(res_q), .res_r(res_r),
    .busy(busy), .div_err(div_err), .state_dbg(state_dbg)
  );

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];   // expected results in order
  logic [15:0]  iss_q[$];   // pairs expected on start, in order
  int n_checks = 0;
  int n_pass = 0;
  int n_starts = 0;
  int rv_cycles = 0;
  int ready_mode = 1;       // 0 hold low, 1 hold high, 2 random
  bit div_auto = 1'b1;      // divider model answers start pulses
  bit stray = 1'b0;         // request one unsolicited done pulse
  bit outstanding = 1'b0;
  bit in_wait = 1'b0;
  logic [15:0] hold_xy = '0;
  bit pending = 1'b0;
  int div_cnt = 0;
  logic [7:0] dx = '0, dy = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_checks++;
    assert (got === expv) n_pass++;
    else $error("FAIL %s got=%0h expected=%0h", tag, got, expv);
  endtask

  // reference: what a pushed pair should eventually produce
  task automatic model_push(input logic [7:0] a, input logic [7:0] b);
    if (TRAP && b == 8'h00) begin
      exp_q.push_back({1'b1, 8'hFF, a});
    end else begin
      iss_q.push_back({a, b});
      if (b == 8'h00) exp_q.push_back({1'b0, 8'hFF, a});
      else            exp_q.push_back({1'b0, 8'(a / b), 8'(a % b)});
    end
  endtask

  // observe outputs at the falling edge
  task automatic monitor();
    if (reset) begin
      outstanding = 1'b0;
      in_wait = 1'b0;
    end else begin
      if (in_wait) check("xy_hold", {x, y}, hold_xy);
      if (start) begin
        n_starts++;
        check("single_outstanding", 32'(outstanding), 0);
        if (iss_q.size() == 0) check("unexpected_start", 1, 0);
        else check("issue_xy", {x, y}, iss_q.pop_front());
        outstanding = 1'b1;
        in_wait = 1'b1;
        hold_xy = {x, y};
      end
      if (res_valid) begin
        in_wait = 1'b0;
        rv_cycles++;
        if (exp_q.size() == 0) check("unexpected_result", 1, 0);
        else check("result", {div_err, res_q, res_r}, exp_q[0]);
        if (res_ready && exp_q.size() != 0) begin
          void'(exp_q.pop_front());
          outstanding = 1'b0;
        end
      end
    end
  endtask

  // external divider model, stepped at the falling edge
  task automatic divider_step();
    done = 1'b0;
    if (reset) pending = 1'b0;
    if (stray) begin
      done = 1'b1;
      quotient = 8'h55;
      remainder = 8'hAA;
      stray = 1'b0;
    end else if (pending) begin
      if (div_cnt == 0) begin
        done = 1'b1;
        quotient = (dy == 0) ? 8'hFF : 8'(dx / dy);
        remainder = (dy == 0) ? dx : 8'(dx % dy);
        pending = 1'b0;
      end else begin
        div_cnt--;
      end
    end
    if (start && !reset && div_auto) begin
      pending = 1'b1;
      div_cnt = $urandom_range(0, 3);
      dx = x;
      dy = y;
    end
  endtask

  // one clock: observe, step divider, cross the edge, drive ready
  task automatic tick();
    @(negedge clk);
    monitor();
    divider_step();
    @(posedge clk);
    #1;
    case (ready_mode)
      0:       res_ready = 1'b0;
      1:       res_ready = 1'b1;
      default: res_ready = 1'($urandom_range(0, 1));
    endcase
  endtask

  // ---------------- driver tasks ----------------
  task automatic push(input logic [7:0] a, input logic [7:0] b, input bit acc);
    wr_en = 1'b1;
    din_x = a;
    din_y = b;
    if (acc) model_push(a, b);
    tick();
    wr_en = 1'b0;
  endtask

  task automatic wait_drain(input int budget, input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (exp_q.size() == 0 && iss_q.size() == 0 && !busy && empty) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    check(tag, 32'(ok), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    int s0;
    bit seen;
    reset = 1'b1; wr_en = 1'b0; din_x = '0; din_y = '0;
    done = 1'b0; quotient = '0; remainder = '0; res_ready = 1'b0;

    // reset for 5 cycles, then check reset values
    repeat (5) tick();
    check("rst_empty", 32'(empty), 1);
    check("rst_full", 32'(full), 0);
    check("rst_start", 32'(start), 0);
    check("rst_res_valid", 32'(res_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_div_err", 32'(div_err), 0);
    check("rst_xy_qr", {x, y, res_q, res_r}, 0);
    reset = 1'b0;

    // single division 3/8 with latency check
    ready_mode = 1;
    tick();
    rv_cycles = 0;
    push(8'd3, 8'd8, 1'b1);
    check("lat_edge_k_start", 32'(start), 0);
    check("lat_edge_k_empty", 32'(empty), 0);
    tick();
    check("lat_edge_k1_start", 32'(start), 1);
    check("lat_edge_k1_busy", 32'(busy), 1);
    check("lat_edge_k1_xy", {x, y}, {8'd3, 8'd8});
    wait_drain(50, "drain_basic");
    check("res_valid_one_cycle", rv_cycles, 1);

    // stall in HOLD, then overfill the FIFO
    ready_mode = 0;
    push(8'd100, 8'd9, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (res_valid) begin seen = 1'b1; break; end
      tick();
    end
    check("stall_reached_hold", 32'(seen), 1);
    for (int i = 0; i < 5; i++) begin
      push(8'(10 * i + 11), 8'(i + 2), i < 4);
      check($sformatf("full_after_push%0d", i + 1), 32'(full), (i >= 3) ? 1 : 0);
    end
    check("full_not_empty", 32'(empty), 0);
    ready_mode = 1;
    wait_drain(100, "drain_overfill");

    // three results under a toggling ready
    ready_mode = 2;
    push(8'd200, 8'd7, 1'b1);
    push(8'd255, 8'd16, 1'b1);
    push(8'd9, 8'd3, 1'b1);
    wait_drain(200, "drain_toggle");

    // randomized traffic, never more than 4 outstanding
    for (int i = 0; i < 60; i++) begin
      ready_mode = 2;
      if (exp_q.size() < 4 && $urandom_range(0, 2) != 0)
        push(8'($urandom_range(0, 255)), 8'($urandom_range(1, 255)), 1'b1);
      else
        tick();
    end
    ready_mode = 1;
    wait_drain(300, "drain_random");

    // reset while waiting for the divider, then a late done
    div_auto = 1'b0;
    s0 = n_starts;
    push(8'd1, 8'd1, 1'b1);
    for (int i = 0; i < 10; i++) begin
      if (n_starts > s0) break;
      tick();
    end
    check("rst_wait_started", n_starts - s0, 1);
    check("rst_wait_busy", 32'(busy), 1);
    reset = 1'b1;
    exp_q.delete();
    iss_q.delete();
    tick();
    tick();
    reset = 1'b0;
    stray = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("post_rst_res_valid", 32'(res_valid), 0);
      check("post_rst_empty", 32'(empty), 1);
      check("post_rst_busy", 32'(busy), 0);
    end
    div_auto = 1'b1;

    // divide by zero
    s0 = n_starts;
    push(8'd42, 8'd0, 1'b1);
    wait_drain(50, "drain_zero");
    check("zero_start_count", n_starts - s0, TRAP ? 0 : 1);
    check("zero_err_cleared", 32'(div_err), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
